xgriscv_halt_monitor: RTL and testbench
=======================================

Name: xgriscv_halt_monitor

Overview:
- Synthesizable run-control monitor that sits directly downstream of xgriscv_pipeline and consumes its pc output.
- Replaces ad-hoc end-of-program detection in the bench with one block that decides when a program has finished.
- Detects three end conditions: the stop address is reached, the pc is stuck in a jump-to-self loop, or a cycle watchdog expires.
- Reports a sticky halt flag, the halt cause, the pc at halt, and cycle/valid-pc counters for the bench or an external debug port.

Parameters:
- ADDR_SIZE, 32, width of pc; matches the `ADDR_SIZE define.
- STOP_ADDR, 32'h000000FC, address of the last program instruction.
- LOOP_LIMIT, 8, number of consecutive valid samples of the same pc that counts as a self-loop. Must be at least 2.
- MAX_CYCLES, 100000, watchdog limit in active cycles. 0 disables the watchdog.
- CNT_W, 32, width of both counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- pc  in  ADDR_SIZE  pc from the pipeline.
- pc_valid  in  1  pc is meaningful this cycle (not a bubble or stall).
- clear  in  1  synchronous restart of the monitor.
- halted  out  1  sticky halt flag.
- halt_pulse  out  1  one-cycle strobe on the halt transition.
- halt_cause  out  2  00 none, 01 stop address, 10 self-loop, 11 watchdog.
- halt_pc  out  ADDR_SIZE  pc captured at halt.
- cycle_count  out  CNT_W  active cycles counted.
- valid_count  out  CNT_W  valid pc samples counted.

Behaviour:
- Reset (rstn=0): takes effect immediately, without waiting for clk.
  - All outputs go to 0; state goes to IDLE.
  - Internal prev_pc, prev_ok and rep_cnt go to 0.
- States:
  - IDLE: counters held at 0.
  - RUN: monitoring.
  - HALTED: all registers frozen.
- Active cycle: state is RUN, or state is IDLE with pc_valid=1. IDLE with pc_valid=1 moves to RUN and is itself evaluated as an active cycle.
- Per active cycle (one rising edge):
  - cycle_count increments by 1.
  - If pc_valid=1, valid_count increments by 1.
  - Both counters saturate at all-ones.
- Self-loop tracking, valid cycles only:
  - If prev_ok=1 and pc==prev_pc, rep_cnt increments.
  - Otherwise rep_cnt is set to 0.
  - Then prev_pc is set to pc and prev_ok to 1.
  - Invalid cycles hold prev_pc and rep_cnt unchanged (stalls and bubbles neither break nor advance a loop).
- Trigger conditions, evaluated on the current cycle's inputs and pre-edge state:
  - A (stop address): pc_valid and pc==STOP_ADDR.
  - L (self-loop): pc_valid, prev_ok, pc==prev_pc and rep_cnt==LOOP_LIMIT-2.
  - W (watchdog): MAX_CYCLES!=0 and cycle_count+1==MAX_CYCLES.
- On any trigger, at that edge:
  - State goes to HALTED; halted=1; halt_pulse=1.
  - halt_cause is set with priority A > L > W when several fire together.
  - halt_pc is set to pc if pc_valid, else prev_pc (0 if prev_ok=0).
  - Counters include the triggering cycle.
- Latency: halted is visible in the cycle after the triggering pc is presented (a single registered stage).
- halt_pulse falls at the next edge.
- HALTED is sticky: pc and pc_valid are ignored; counters, halt_cause and halt_pc hold.
- clear=1 is evaluated at the edge in any state and has priority over triggers. It returns the block to IDLE with every output and internal register at its reset value.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Stop address: pc_valid=1, pc=0,4,8…0xFC, one per cycle. Required at the edge sampling 0xFC: halted=1, halt_cause=01, halt_pc=0xFC, cycle_count=64, valid_count=64, halt_pulse high for exactly 1 cycle. Later pc values cause no change.
2. Self-loop: pc=0x10, then 0x14 held with valid=1, LOOP_LIMIT=8. Required: halt at the 8th sample of 0x14 with cause=10, halt_pc=0x14, valid_count=9.
3. Stall interleave: same as test 2 but pc_valid=0 on every other cycle. Required: halt still after 8 valid 0x14 samples, with valid_count=9 and cycle_count=16. A single different pc mid-sequence resets rep_cnt, and the halt is delayed accordingly.
4. Watchdog and priority:
   - MAX_CYCLES=20 with incrementing pc that never hits 0xFC: halt with cause=11 and cycle_count=20.
   - Arrange pc=0xFC on cycle 20: cause=01 (A beats W).
5. Gaps and clear:
   - 5 idle cycles with pc_valid=0 after reset: counters stay 0.
   - After a halt, pulse clear for 1 cycle: all outputs return to 0 and state is IDLE.
   - Rerunning test 1 reproduces identical results.
6. Asynchronous reset mid-run: drop rstn between clock edges at cycle 30. Required: outputs go to 0 before the next edge. Release rstn, then rerun test 1: results are correct.

Source files
------------

// File: rtl/xgriscv_halt_monitor_if.sv
// Signal bundle between the pipeline-side driver and the halt monitor.
// The master drives the pc stream and clear; the monitor (slave) returns halt status and counters.
interface xgriscv_halt_monitor_if #(
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned CNT_W     = 32
);
    logic [ADDR_SIZE-1:0] pc;
    logic                 pc_valid;
    logic                 clear;
    logic                 halted;
    logic                 halt_pulse;
    logic [1:0]           halt_cause;
    logic [ADDR_SIZE-1:0] halt_pc;
    logic [CNT_W-1:0]     cycle_count;
    logic [CNT_W-1:0]     valid_count;

    modport master (
        output pc, pc_valid, clear,
        input  halted, halt_pulse, halt_cause, halt_pc, cycle_count, valid_count
    );

    modport slave (
        input  pc, pc_valid, clear,
        output halted, halt_pulse, halt_cause, halt_pc, cycle_count, valid_count
    );
endinterface

// File: rtl/xgriscv_halt_monitor.sv
// Run-control monitor on the pipeline pc stream: halts on the stop address, a jump-to-self loop,
// or a cycle watchdog, and reports the cause, the halting pc and cycle/valid-pc counters.
module xgriscv_halt_monitor #(
    parameter int unsigned          ADDR_SIZE  = 32,
    parameter logic [ADDR_SIZE-1:0] STOP_ADDR  = 'h000000FC,
    parameter int unsigned          LOOP_LIMIT = 8,
    parameter int unsigned          MAX_CYCLES = 100000,
    parameter int unsigned          CNT_W      = 32
) (
    input logic                   clk,
    input logic                   rstn,
    xgriscv_halt_monitor_if.slave mon
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseStop  = 2'b01;
    localparam logic [1:0] CauseLoop  = 2'b10;
    localparam logic [1:0] CauseWdog  = 2'b11;

    // rep_cnt never exceeds LOOP_LIMIT-1 because the loop trigger halts first.
    localparam int unsigned     REP_W    = $clog2(LOOP_LIMIT) + 1;
    localparam logic [REP_W-1:0] REP_TRIG = REP_W'(LOOP_LIMIT - 2);
    localparam int unsigned     CW1      = CNT_W + 1;
    localparam logic [CW1-1:0]  WD_LAST  = CW1'(MAX_CYCLES) - CW1'(1);

    logic [1:0]           state_q, state_d;
    logic                 halted_q, halted_d;
    logic                 halt_pulse_q, halt_pulse_d;
    logic [1:0]           halt_cause_q, halt_cause_d;
    logic [ADDR_SIZE-1:0] halt_pc_q, halt_pc_d;
    logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]     valid_count_q, valid_count_d;
    logic [ADDR_SIZE-1:0] prev_pc_q, prev_pc_d;
    logic                 prev_ok_q, prev_ok_d;
    logic [REP_W-1:0]     rep_cnt_q, rep_cnt_d;

    logic active;
    logic same_pc;
    logic trig_a, trig_l, trig_w;

    always_comb begin
        active  = (state_q == StRun) || ((state_q == StIdle) && mon.pc_valid);
        same_pc = prev_ok_q && (mon.pc == prev_pc_q);
        trig_a  = mon.pc_valid && (mon.pc == STOP_ADDR);
        trig_l  = mon.pc_valid && same_pc && (rep_cnt_q == REP_TRIG);
        trig_w  = (MAX_CYCLES != 0) && ({1'b0, cycle_count_q} == WD_LAST);
    end

    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        halt_pulse_d  = 1'b0;
        halt_cause_d  = halt_cause_q;
        halt_pc_d     = halt_pc_q;
        cycle_count_d = cycle_count_q;
        valid_count_d = valid_count_q;
        prev_pc_d     = prev_pc_q;
        prev_ok_d     = prev_ok_q;
        rep_cnt_d     = rep_cnt_q;

        if (mon.clear) begin
            state_d       = StIdle;
            halted_d      = 1'b0;
            halt_cause_d  = CauseNone;
            halt_pc_d     = '0;
            cycle_count_d = '0;
            valid_count_d = '0;
            prev_pc_d     = '0;
            prev_ok_d     = 1'b0;
            rep_cnt_d     = '0;
        end else if ((state_q != StHalted) && active) begin
            state_d = StRun;
            if (~&cycle_count_q) cycle_count_d = cycle_count_q + CNT_W'(1);
            if (mon.pc_valid) begin
                if (~&valid_count_q) valid_count_d = valid_count_q + CNT_W'(1);
                rep_cnt_d = same_pc ? rep_cnt_q + REP_W'(1) : '0;
                prev_pc_d = mon.pc;
                prev_ok_d = 1'b1;
            end

            if (trig_a || trig_l || trig_w) begin
                state_d      = StHalted;
                halted_d     = 1'b1;
                halt_pulse_d = 1'b1;
                if (trig_a)      halt_cause_d = CauseStop;
                else if (trig_l) halt_cause_d = CauseLoop;
                else             halt_cause_d = CauseWdog;
                // prev_pc_q is still zero when no valid pc has been seen yet.
                halt_pc_d = mon.pc_valid ? mon.pc : prev_pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            halted_q      <= 1'b0;
            halt_pulse_q  <= 1'b0;
            halt_cause_q  <= CauseNone;
            halt_pc_q     <= '0;
            cycle_count_q <= '0;
            valid_count_q <= '0;
            prev_pc_q     <= '0;
            prev_ok_q     <= 1'b0;
            rep_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            halt_pulse_q  <= halt_pulse_d;
            halt_cause_q  <= halt_cause_d;
            halt_pc_q     <= halt_pc_d;
            cycle_count_q <= cycle_count_d;
            valid_count_q <= valid_count_d;
            prev_pc_q     <= prev_pc_d;
            prev_ok_q     <= prev_ok_d;
            rep_cnt_q     <= rep_cnt_d;
        end
    end

    assign mon.halted      = halted_q;
    assign mon.halt_pulse  = halt_pulse_q;
    assign mon.halt_cause  = halt_cause_q;
    assign mon.halt_pc     = halt_pc_q;
    assign mon.cycle_count = cycle_count_q;
    assign mon.valid_count = valid_count_q;

endmodule

// File: tb/tb_xgriscv_halt_monitor.sv
// Directed bench for xgriscv_halt_monitor: stop address, self-loop, stalls, watchdog priority,
// clear and asynchronous reset, using one default instance and one with a short watchdog.
module tb_xgriscv_halt_monitor;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    xgriscv_halt_monitor_if #(.ADDR_SIZE(32), .CNT_W(32)) ifa ();
    xgriscv_halt_monitor_if #(.ADDR_SIZE(32), .CNT_W(32)) ifw ();

    xgriscv_halt_monitor #(
        .ADDR_SIZE (32),
        .STOP_ADDR (32'h000000FC),
        .LOOP_LIMIT(8),
        .MAX_CYCLES(100000),
        .CNT_W     (32)
    ) dut_a (
        .clk (clk),
        .rstn(rstn),
        .mon (ifa.slave)
    );

    xgriscv_halt_monitor #(
        .ADDR_SIZE (32),
        .STOP_ADDR (32'h000000FC),
        .LOOP_LIMIT(8),
        .MAX_CYCLES(20),
        .CNT_W     (32)
    ) dut_w (
        .clk (clk),
        .rstn(rstn),
        .mon (ifw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [31:0] p, input logic v);
        ifa.pc       = p;
        ifa.pc_valid = v;
        tick();
    endtask

    task automatic drive_w(input logic [31:0] p, input logic v);
        ifw.pc       = p;
        ifw.pc_valid = v;
        tick();
    endtask

    task automatic clear_a();
        ifa.clear    = 1'b1;
        ifa.pc_valid = 1'b0;
        tick();
        ifa.clear = 1'b0;
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_halted"}, {31'd0, ifa.halted}, 32'd0);
        check({tag, "_pulse"}, {31'd0, ifa.halt_pulse}, 32'd0);
        check({tag, "_cause"}, {30'd0, ifa.halt_cause}, 32'd0);
        check({tag, "_hpc"}, ifa.halt_pc, 32'd0);
        check({tag, "_cyc"}, ifa.cycle_count, 32'd0);
        check({tag, "_val"}, ifa.valid_count, 32'd0);
    endtask

    // Walk pc 0,4,...,0xFC from IDLE; halt must land on the 64th sample.
    task automatic run_stop(input string tag);
        for (int i = 0; i < 64; i++) begin
            drive_a(32'(i * 4), 1'b1);
            if (i == 62) check({tag, "_early"}, {31'd0, ifa.halted}, 32'd0);
        end
        check({tag, "_halted"}, {31'd0, ifa.halted}, 32'd1);
        check({tag, "_pulse"}, {31'd0, ifa.halt_pulse}, 32'd1);
        check({tag, "_cause"}, {30'd0, ifa.halt_cause}, 32'd1);
        check({tag, "_hpc"}, ifa.halt_pc, 32'h000000FC);
        check({tag, "_cyc"}, ifa.cycle_count, 32'd64);
        check({tag, "_val"}, ifa.valid_count, 32'd64);
        drive_a(32'h00000100, 1'b1);
        drive_a(32'h00000100, 1'b1);
        check({tag, "_pulse_fall"}, {31'd0, ifa.halt_pulse}, 32'd0);
        check({tag, "_sticky"}, {31'd0, ifa.halted}, 32'd1);
        check({tag, "_hold_cyc"}, ifa.cycle_count, 32'd64);
        check({tag, "_hold_hpc"}, ifa.halt_pc, 32'h000000FC);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        ifa.pc       = '0;
        ifa.pc_valid = 1'b0;
        ifa.clear    = 1'b0;
        ifw.pc       = '0;
        ifw.pc_valid = 1'b0;
        ifw.clear    = 1'b0;
        rstn         = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check_zero_a("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Idle gap: invalid pcs in IDLE are not active cycles.
        for (int i = 0; i < 5; i++) drive_a(32'h000000FC, 1'b0);
        check("idle_cyc", ifa.cycle_count, 32'd0);
        check("idle_val", ifa.valid_count, 32'd0);
        check("idle_halted", {31'd0, ifa.halted}, 32'd0);

        run_stop("stop1");

        clear_a();
        check_zero_a("clear");
        drive_a(32'h00000040, 1'b0);
        check("clear_idle_cyc", ifa.cycle_count, 32'd0);
        run_stop("stop2");

        // Self-loop: 0x10 then eight samples of 0x14.
        clear_a();
        drive_a(32'h00000010, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            drive_a(32'h00000014, 1'b1);
            if (k == 7) check("loop_early", {31'd0, ifa.halted}, 32'd0);
        end
        check("loop_halted", {31'd0, ifa.halted}, 32'd1);
        check("loop_cause", {30'd0, ifa.halt_cause}, 32'd2);
        check("loop_hpc", ifa.halt_pc, 32'h00000014);
        check("loop_val", ifa.valid_count, 32'd9);
        check("loop_cyc", ifa.cycle_count, 32'd9);

        // Stalls interleaved; the invalid pc is the stop address and must be ignored.
        clear_a();
        drive_a(32'h00000010, 1'b1);
        drive_a(32'h00000014, 1'b1);
        for (int k = 0; k < 7; k++) begin
            drive_a(32'h000000FC, 1'b0);
            if (k == 6) check("stall_early", {31'd0, ifa.halted}, 32'd0);
            drive_a(32'h00000014, 1'b1);
        end
        check("stall_halted", {31'd0, ifa.halted}, 32'd1);
        check("stall_cause", {30'd0, ifa.halt_cause}, 32'd2);
        check("stall_hpc", ifa.halt_pc, 32'h00000014);
        check("stall_val", ifa.valid_count, 32'd9);
        check("stall_cyc", ifa.cycle_count, 32'd16);

        // A different pc mid-loop restarts the repeat count.
        clear_a();
        drive_a(32'h00000010, 1'b1);
        for (int k = 0; k < 3; k++) drive_a(32'h00000014, 1'b1);
        drive_a(32'h00000018, 1'b1);
        for (int k = 0; k < 7; k++) drive_a(32'h00000014, 1'b1);
        check("break_early", {31'd0, ifa.halted}, 32'd0);
        drive_a(32'h00000014, 1'b1);
        check("break_halted", {31'd0, ifa.halted}, 32'd1);
        check("break_cause", {30'd0, ifa.halt_cause}, 32'd2);
        check("break_val", ifa.valid_count, 32'd13);

        // Watchdog on the 20-cycle instance.
        ifa.pc_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_w(32'(i * 4), 1'b1);
            if (i == 18) check("wd_early", {31'd0, ifw.halted}, 32'd0);
        end
        check("wd_halted", {31'd0, ifw.halted}, 32'd1);
        check("wd_cause", {30'd0, ifw.halt_cause}, 32'd3);
        check("wd_cyc", ifw.cycle_count, 32'd20);
        check("wd_val", ifw.valid_count, 32'd20);
        check("wd_hpc", ifw.halt_pc, 32'h0000004C);

        // Stop address on the watchdog cycle wins.
        ifw.clear    = 1'b1;
        ifw.pc_valid = 1'b0;
        tick();
        ifw.clear = 1'b0;
        check("wd_clear_halted", {31'd0, ifw.halted}, 32'd0);
        for (int i = 0; i < 20; i++) drive_w(32'h000000B0 + 32'(i * 4), 1'b1);
        check("prio_cause", {30'd0, ifw.halt_cause}, 32'd1);
        check("prio_hpc", ifw.halt_pc, 32'h000000FC);
        check("prio_cyc", ifw.cycle_count, 32'd20);
        ifw.pc_valid = 1'b0;

        // Asynchronous reset between edges at cycle 30.
        clear_a();
        for (int i = 0; i < 30; i++) drive_a(32'(i * 4), 1'b1);
        check("pre_rst_cyc", ifa.cycle_count, 32'd30);
        #3 rstn = 1'b0;
        #1;
        check_zero_a("async");
        check("async_w_halted", {31'd0, ifw.halted}, 32'd0);
        check("async_w_cause", {30'd0, ifw.halt_cause}, 32'd0);
        #1 rstn = 1'b1;
        ifa.pc_valid = 1'b0;
        tick();
        check("post_rst_cyc", ifa.cycle_count, 32'd0);
        run_stop("stop3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
